// File: rtl/mcpu_pkg.sv
// Shared multicycle CPU definitions: FSM states, opcode classes and constants,
// ALU operation codes and PC source selects. Also used by the ALU and datapath.
package mcpu_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CLS_ALU_R,
    CLS_ALU_I,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_BNE,
    CLS_JMP,
    CLS_HALT,
    CLS_ILL
  } op_class_t;

  localparam logic [1:0] OPC_ALU_R = 2'b00;
  localparam logic [1:0] OPC_ALU_I = 2'b01;

  localparam logic [5:0] OP_LW   = 6'b100000;
  localparam logic [5:0] OP_SW   = 6'b100001;
  localparam logic [5:0] OP_BEQ  = 6'b110000;
  localparam logic [5:0] OP_BNE  = 6'b110001;
  localparam logic [5:0] OP_JMP  = 6'b110010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [3:0] ALU_MOV = 4'b0000;
  localparam logic [3:0] ALU_NOT = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0011;
  localparam logic [3:0] ALU_OR  = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0101;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_LI  = 4'b1001;
  localparam logic [3:0] ALU_SWI = 4'b1100;

  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  function automatic logic alu_code_legal(input logic [3:0] code);
    case (code)
      ALU_MOV, ALU_NOT, ALU_ADD, ALU_SUB, ALU_OR,
      ALU_AND, ALU_SLT, ALU_LI, ALU_SWI: alu_code_legal = 1'b1;
      default:                           alu_code_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Memory request/acknowledge handshake between the control FSM and memory.
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_ack;

  modport master (output mem_req, output mem_we, output mem_addr_sel, input mem_ack);
  modport slave  (input mem_req, input mem_we, input mem_addr_sel, output mem_ack);
endinterface

// File: rtl/mcpu_op_decode.sv
// Combinational opcode decoder: instruction class, ALU operation and legality.
module mcpu_op_decode
  import mcpu_pkg::*;
(
  input  logic [5:0] op,
  output op_class_t  op_class,
  output logic [3:0] alu_sel,
  output logic       legal
);

  always_comb begin
    op_class = CLS_ILL;
    alu_sel  = ALU_MOV;
    legal    = 1'b0;
    if (op[5:4] == OPC_ALU_R || op[5:4] == OPC_ALU_I) begin
      if (alu_code_legal(op[3:0])) begin
        op_class = (op[5:4] == OPC_ALU_I) ? CLS_ALU_I : CLS_ALU_R;
        alu_sel  = op[3:0];
        legal    = 1'b1;
      end
    end else begin
      case (op)
        OP_LW:   begin op_class = CLS_LW;   alu_sel = ALU_ADD; legal = 1'b1; end
        OP_SW:   begin op_class = CLS_SW;   alu_sel = ALU_ADD; legal = 1'b1; end
        OP_BEQ:  begin op_class = CLS_BEQ;  alu_sel = ALU_SUB; legal = 1'b1; end
        OP_BNE:  begin op_class = CLS_BNE;  alu_sel = ALU_SUB; legal = 1'b1; end
        OP_JMP:  begin op_class = CLS_JMP;  legal = 1'b1; end
        OP_HALT: begin op_class = CLS_HALT; legal = 1'b1; end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM with memory handshake and retired-instruction counter.
// MCTRL_ILLEGAL_TRAP_EN: illegal opcodes trap to HALT (else retire as NOP).
module multicycle_ctrl
  import mcpu_pkg::*;
#(
  parameter int unsigned PC_INC = 4,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             beq_alu,
  multicycle_ctrl_if.master mem,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic [7:0]       pc_inc,
  output logic [3:0]       alu_sel,
  output logic             alu_src_b,
  output logic             reg_write,
  output logic             wb_sel,
  output logic             halted,
  output logic             illegal_op,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  state_t     state_q, state_d;
  op_class_t  op_class;
  logic [3:0] dec_alu;
  logic       dec_legal;
  logic       use_imm;
  logic       ack;
  logic       retire;
  logic       mem_we_c, mem_addr_sel_c;
  logic       unused_ok;
`ifdef MCTRL_ILLEGAL_TRAP_EN
  logic       trap;
  logic       illegal_q;
`endif

  mcpu_op_decode u_dec (
    .op       (instr[31:26]),
    .op_class (op_class),
    .alu_sel  (dec_alu),
    .legal    (dec_legal)
  );

  assign unused_ok = ^{instr[25:0], dec_legal};
  assign use_imm   = (op_class == CLS_ALU_I) || (op_class == CLS_LW) || (op_class == CLS_SW);

  // Gating with rst_n makes the request drop the instant reset asserts, and
  // an ack only counts while a request is actually being presented.
  assign mem.mem_req      = rst_n && (state_q == S_FETCH || state_q == S_MEM);
  assign mem.mem_we       = mem_we_c;
  assign mem.mem_addr_sel = mem_addr_sel_c;
  assign ack              = mem.mem_req && mem.mem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    ir_write       = 1'b0;
    pc_write       = 1'b0;
    pc_src         = PC_SRC_SEQ;
    alu_sel        = ALU_MOV;
    alu_src_b      = 1'b0;
    reg_write      = 1'b0;
    wb_sel         = 1'b0;
    mem_we_c       = 1'b0;
    mem_addr_sel_c = 1'b0;
    retire         = 1'b0;
`ifdef MCTRL_ILLEGAL_TRAP_EN
    trap           = 1'b0;
`endif
    case (state_q)
      S_FETCH: begin
        if (ack) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        case (op_class)
          CLS_HALT: state_d = S_HALT;
          CLS_ILL: begin
`ifdef MCTRL_ILLEGAL_TRAP_EN
            trap    = 1'b1;
            state_d = S_HALT;
`else
            retire  = 1'b1;
            state_d = S_FETCH;
`endif
          end
          default:  state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        alu_sel   = dec_alu;
        alu_src_b = use_imm;
        case (op_class)
          CLS_LW, CLS_SW: state_d = S_MEM;
          CLS_BEQ, CLS_BNE: begin
            pc_write = (op_class == CLS_BEQ) ? beq_alu : !beq_alu;
            pc_src   = pc_write ? PC_SRC_BRANCH : PC_SRC_SEQ;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end
          CLS_JMP: begin
            pc_write = 1'b1;
            pc_src   = PC_SRC_JUMP;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        alu_sel        = dec_alu;
        alu_src_b      = use_imm;
        mem_addr_sel_c = 1'b1;
        mem_we_c       = (op_class == CLS_SW);
        if (ack) begin
          if (op_class == CLS_SW) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        alu_sel   = dec_alu;
        alu_src_b = use_imm;
        reg_write = 1'b1;
        wb_sel    = (op_class == CLS_LW);
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instr_count <= '0;
    else if (retire) instr_count <= instr_count + CNT_W'(1);
  end

`ifdef MCTRL_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    illegal_q <= 1'b0;
    else if (trap) illegal_q <= 1'b1;
  end
  assign illegal_op = illegal_q;
`else
  assign illegal_op = 1'b0;
`endif

  assign halted = (state_q == S_HALT);
  assign state  = state_q;
  assign pc_inc = 8'(PC_INC);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: vector table, hand sequences and
// randomized instructions against a per-instruction behavioural model.
module tb_multicycle_ctrl;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   instr;
  logic          beq_alu;
  logic          ir_write, pc_write, alu_src_b, reg_write, wb_sel, halted, illegal_op;
  logic [1:0]    pc_src;
  logic [7:0]    pc_inc;
  logic [3:0]    alu_sel;
  logic [2:0]    state;
  logic [CW-1:0] instr_count;

  multicycle_ctrl_if mif();

  multicycle_ctrl #(.PC_INC(4), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .beq_alu(beq_alu), .mem(mif),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .pc_inc(pc_inc),
    .alu_sel(alu_sel), .alu_src_b(alu_src_b), .reg_write(reg_write), .wb_sel(wb_sel),
    .halted(halted), .illegal_op(illegal_op), .state(state), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] cycles;
    logic [7:0] memc;
    logic       regw;
    logic       wbsel;
    logic [3:0] alu;
    logic       srcb;
    logic       pcw;
    logic [1:0] pcsrc;
    logic       we;
    logic       halt;
    logic       fetch_bad;
    logic       unstable;
    logic       timeout;
  } obs_t;

  typedef struct {
    logic [5:0] op;
    logic       beq;
    logic [7:0] wf;
    logic [7:0] wm;
    logic [7:0] exp_cycles;
    logic       exp_regw;
    logic       exp_wbsel;
    logic       exp_pcw;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  int mcount   = 0;
  bit mill     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Whole-instruction expectations derived from the opcode rules.
  function automatic obs_t model(input logic [5:0] op, input logic beq,
                                 input logic [7:0] wf, input logic [7:0] wm,
                                 output bit ret, output bit ill);
    obs_t e;
    e = '0; ret = 1'b0; ill = 1'b0;
    if (op[5] == 1'b0) begin
      if (op[3:0] inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd9, 4'd12}) begin
        e.cycles = 8'(4 + wf); e.regw = 1'b1; e.alu = op[3:0]; e.srcb = op[4]; ret = 1'b1;
      end else ill = 1'b1;
    end else begin
      case (op)
        6'b100000: begin
          e.cycles = 8'(5 + wf + wm); e.memc = 8'(wm + 1); e.regw = 1'b1;
          e.wbsel = 1'b1; e.alu = 4'b0010; e.srcb = 1'b1; ret = 1'b1;
        end
        6'b100001: begin
          e.cycles = 8'(4 + wf + wm); e.memc = 8'(wm + 1); e.we = 1'b1; ret = 1'b1;
        end
        6'b110000: begin e.cycles = 8'(3 + wf); e.pcw = beq;  e.pcsrc = beq ? 2'd1 : 2'd0; ret = 1'b1; end
        6'b110001: begin e.cycles = 8'(3 + wf); e.pcw = !beq; e.pcsrc = beq ? 2'd0 : 2'd1; ret = 1'b1; end
        6'b110010: begin e.cycles = 8'(3 + wf); e.pcw = 1'b1; e.pcsrc = 2'd2; ret = 1'b1; end
        6'b111111: begin e.cycles = 8'(3 + wf); e.halt = 1'b1; end
        default:   ill = 1'b1;
      endcase
    end
    if (ill) begin
`ifdef MCTRL_ILLEGAL_TRAP_EN
      e.halt = 1'b1; e.cycles = 8'(3 + wf);
`else
      e.cycles = 8'(2 + wf); ret = 1'b1; ill = 1'b0;
`endif
    end
    return e;
  endfunction

  // Starts at a negedge with the DUT in FETCH; returns at the negedge where
  // FETCH is re-entered, or where HALT is first observed.
  task automatic run_instr(input logic [5:0] op, input logic beq,
                           input logic [7:0] wf, input logic [7:0] wm, output obs_t o);
    bit left = 1'b0, prev_req = 1'b0, prev_ack = 1'b0, new_acc;
    bit acc_we = 1'b0, acc_sel = 1'b0;
    int unsigned wl = 0;
    int cyc = 0;
    o = '0;
    instr   = {op, 26'($urandom)};
    beq_alu = beq;
    while (1) begin
      if (left && state == 3'd0) break;
      if (cyc >= 64) begin o.timeout = 1'b1; break; end
      new_acc = !prev_req || prev_ack;
      if (mif.mem_req) begin
        if (new_acc) wl = mif.mem_addr_sel ? int'(wm) : int'(wf);
        mif.mem_ack = (wl == 0);
        if (wl != 0) wl--;
      end else mif.mem_ack = 1'($urandom_range(0, 1));
      #1;
      if (state == 3'd0 && mif.mem_req && mif.mem_ack) begin
        if (!(ir_write && pc_write && pc_src == 2'b00)) o.fetch_bad = 1'b1;
      end else if (ir_write) o.fetch_bad = 1'b1;
      if (state == 3'd0 && (mif.mem_we || mif.mem_addr_sel)) o.fetch_bad = 1'b1;
      if (pc_write && state != 3'd0) begin o.pcw = 1'b1; o.pcsrc = pc_src; end
      if (reg_write) begin o.regw = 1'b1; o.wbsel = wb_sel; o.alu = alu_sel; o.srcb = alu_src_b; end
      if (mif.mem_req && mif.mem_addr_sel) begin
        o.memc = o.memc + 8'd1;
        o.we   = o.we | mif.mem_we;
      end
      if (mif.mem_req) begin
        if (new_acc) begin acc_we = mif.mem_we; acc_sel = mif.mem_addr_sel; end
        else if (acc_we != mif.mem_we || acc_sel != mif.mem_addr_sel) o.unstable = 1'b1;
      end
      prev_req = mif.mem_req;
      prev_ack = mif.mem_ack;
      cyc++;
      if (state == 3'd5) begin o.halt = 1'b1; break; end
      if (state != 3'd0) left = 1'b1;
      @(negedge clk);
    end
    o.cycles    = 8'(cyc);
    mif.mem_ack = 1'b0;
  endtask

  task automatic compare(input string tag, input obs_t o, input obs_t e);
    check({tag, ".timeout"},  32'(o.timeout),   32'(e.timeout));
    check({tag, ".cycles"},   32'(o.cycles),    32'(e.cycles));
    check({tag, ".regw"},     32'(o.regw),      32'(e.regw));
    check({tag, ".wbsel"},    32'(o.wbsel),     32'(e.wbsel));
    check({tag, ".alu"},      32'(o.alu),       32'(e.alu));
    check({tag, ".srcb"},     32'(o.srcb),      32'(e.srcb));
    check({tag, ".pcw"},      32'(o.pcw),       32'(e.pcw));
    check({tag, ".pcsrc"},    32'(o.pcsrc),     32'(e.pcsrc));
    check({tag, ".memc"},     32'(o.memc),      32'(e.memc));
    check({tag, ".we"},       32'(o.we),        32'(e.we));
    check({tag, ".halt"},     32'(o.halt),      32'(e.halt));
    check({tag, ".fetch"},    32'(o.fetch_bad), 32'(e.fetch_bad));
    check({tag, ".stable"},   32'(o.unstable),  32'(e.unstable));
  endtask

  task automatic do_instr(input string tag, input logic [5:0] op, input logic beq,
                          input logic [7:0] wf, input logic [7:0] wm, output obs_t o, output obs_t e);
    bit ret, ill;
    e = model(op, beq, wf, wm, ret, ill);
    run_instr(op, beq, wf, wm, o);
    compare(tag, o, e);
    if (ret) mcount++;
    if (ill) mill = 1'b1;
    check({tag, ".count"},   32'(instr_count), 32'(mcount % (1 << CW)));
    check({tag, ".illegal"}, 32'(illegal_op),  32'(mill));
    check({tag, ".halted"},  32'(halted),      32'(e.halt));
  endtask

  task automatic hold_halt(input string tag);
    bit ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      mif.mem_ack = 1'($urandom_range(0, 1));
      #1;
      if (state !== 3'd5 || halted !== 1'b1 || mif.mem_req !== 1'b0 ||
          illegal_op !== 1'(mill) || instr_count !== CW'(mcount)) ok = 1'b0;
    end
    mif.mem_ack = 1'b0;
    check({tag, ".halt_hold"}, 32'(ok), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; mif.mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    mcount = 0;
    mill   = 1'b0;
  endtask

  vec_t vec[10];
  obs_t o, e;
  logic [5:0] rop;
  bit rret, rill;

  initial begin
    vec[0] = '{6'b000010, 1'b0, 8'd0, 8'd0, 8'd4, 1'b1, 1'b0, 1'b0};
    vec[1] = '{6'b100000, 1'b0, 8'd0, 8'd3, 8'd8, 1'b1, 1'b1, 1'b0};
    vec[2] = '{6'b100001, 1'b0, 8'd0, 8'd0, 8'd4, 1'b0, 1'b0, 1'b0};
    vec[3] = '{6'b110000, 1'b1, 8'd0, 8'd0, 8'd3, 1'b0, 1'b0, 1'b1};
    vec[4] = '{6'b110001, 1'b1, 8'd0, 8'd0, 8'd3, 1'b0, 1'b0, 1'b0};
    vec[5] = '{6'b110001, 1'b0, 8'd0, 8'd0, 8'd3, 1'b0, 1'b0, 1'b1};
    vec[6] = '{6'b110010, 1'b0, 8'd2, 8'd0, 8'd5, 1'b0, 1'b0, 1'b1};
    vec[7] = '{6'b010011, 1'b0, 8'd1, 8'd0, 8'd5, 1'b1, 1'b0, 1'b0};
    vec[8] = '{6'b001001, 1'b0, 8'd0, 8'd0, 8'd4, 1'b1, 1'b0, 1'b0};
`ifdef MCTRL_ILLEGAL_TRAP_EN
    vec[9] = '{6'b000110, 1'b0, 8'd0, 8'd0, 8'd3, 1'b0, 1'b0, 1'b0};
`else
    vec[9] = '{6'b000110, 1'b0, 8'd0, 8'd0, 8'd2, 1'b0, 1'b0, 1'b0};
`endif

    rst_n = 1'b0; instr = '0; beq_alu = 1'b0; mif.mem_ack = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst.state",   32'(state),       32'd0);
    check("rst.count",   32'(instr_count), 32'd0);
    check("rst.flags",   32'({illegal_op, halted, mif.mem_req}), 32'd0);
    check("rst.enables", 32'({ir_write, pc_write, reg_write, mif.mem_we, mif.mem_addr_sel,
                              alu_src_b, wb_sel}), 32'd0);
    check("rst.sels",    32'({pc_src, alu_sel}), 32'd0);
    check("pc_inc",      32'(pc_inc), 32'd4);
    mif.mem_ack = 1'b0;
    rst_n = 1'b1;
    #1;
    check("rst.req_after", 32'(mif.mem_req), 32'd1);

    for (int i = 0; i < 10; i++) begin
      do_instr($sformatf("vec%0d", i), vec[i].op, vec[i].beq, vec[i].wf, vec[i].wm, o, e);
      check($sformatf("vec%0d.tbl_cycles", i), 32'(o.cycles), 32'(vec[i].exp_cycles));
      check($sformatf("vec%0d.tbl_regw", i),   32'(o.regw),   32'(vec[i].exp_regw));
      check($sformatf("vec%0d.tbl_wbsel", i),  32'(o.wbsel),  32'(vec[i].exp_wbsel));
      check($sformatf("vec%0d.tbl_pcw", i),    32'(o.pcw),    32'(vec[i].exp_pcw));
      if (o.halt || e.halt) begin
        hold_halt($sformatf("vec%0d", i));
        do_reset();
      end
    end

    // Reset asserted in the middle of a LW memory access.
    do_instr("pre_rst_add", 6'b000010, 1'b0, 8'd0, 8'd0, o, e);
    instr = {6'b100000, 26'd0};
    mif.mem_ack = 1'b1;
    @(negedge clk);
    mif.mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("midmem.state", 32'(state), 32'd3);
    check("midmem.req",   32'(mif.mem_req), 32'd1);
    #2;
    rst_n = 1'b0; mif.mem_ack = 1'b1;
    #1;
    check("midmem.req_drop", 32'(mif.mem_req), 32'd0);
    check("midmem.state0",   32'(state), 32'd0);
    check("midmem.count0",   32'(instr_count), 32'd0);
    check("midmem.no_write", 32'({ir_write, pc_write, reg_write}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; mif.mem_ack = 1'b0;
    mcount = 0; mill = 1'b0;
    #1;
    check("midmem.req_back", 32'(mif.mem_req), 32'd1);
    check("midmem.count_back", 32'(instr_count), 32'd0);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) < 7) begin
        case ($urandom_range(0, 7))
          0: rop = 6'b100000;
          1: rop = 6'b100001;
          2: rop = 6'b110000;
          3: rop = 6'b110001;
          4: rop = 6'b110010;
          default: rop = {1'b0, 1'($urandom), 4'($urandom)};
        endcase
      end else rop = 6'($urandom);
      void'(model(rop, 1'b0, 8'd0, 8'd0, rret, rill));
      e = model(rop, 1'b0, 8'd0, 8'd0, rret, rill);
      if (e.halt) rop = 6'b000010;
      do_instr($sformatf("rnd%0d", i), rop, 1'($urandom), 8'($urandom_range(0, 3)),
               8'($urandom_range(0, 3)), o, e);
    end

    // Counter wrap, then HALT absorbs.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      do_instr($sformatf("wrap%0d", i), 6'b000010, 1'b0, 8'($urandom_range(0, 1)), 8'd0, o, e);
    end
    check("wrap.zero", 32'(instr_count), 32'd0);
    do_instr("halt", 6'b111111, 1'b0, 8'd1, 8'd0, o, e);
    hold_halt("halt");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
